hex_digit_packer: RTL
=====================

Name: hex_digit_packer

Overview:
- Inverse of the display nibble selector: builds a 32-bit hex value one 4-bit digit at a time from keypad/switch entry.
- Each digit is entered as a level-held strobe; the working word is presented live for display.
- On commit, the working word is latched into a committed output word for downstream logic.
- Sits between the input debouncers and the seven-segment display path.

Parameters:
DIGITS, 8, number of hex digits held (word width = 4*DIGITS)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
digVal  input  4  hex digit to enter
digEn  input  1  enter-digit request, level; acts on rising edge
bspEn  input  1  backspace request, level; acts on rising edge
clrEn  input  1  clear request, level; acts on rising edge
commitEn  input  1  commit request, level; acts on rising edge
workVal  output  4*DIGITS  live working word; most recent digit in [3:0]
outVal  output  4*DIGITS  last committed word
digCount  output  4  number of digits currently entered, 0..DIGITS
full  output  1  high when digCount == DIGITS
ovf  output  1  sticky: digit entry attempted while full
outValid  output  1  one-cycle pulse on commit

Behaviour:
- Reset (async, active-high):
  - workVal, outVal, digCount, ovf, outValid = 0; full = 0.
  - All edge-detect history registers = 0, so a request held high through reset release fires once on the first clock.
- Edge detection:
  - Each request has a history register.
  - An event occurs on the clock edge where the request is 1 and its history is 0.
  - History updates every clock.
- Latency: state updates on the same clock edge the event is detected; outputs are valid immediately after that edge.
- Priority when several events occur on one edge: clr > commit > bsp > digit. Only the highest-priority event acts; the others are discarded, not queued.
- clr: workVal = 0, digCount = 0, ovf = 0. outVal is unchanged.
- commit:
  - outVal = workVal; outValid = 1 for exactly one cycle.
  - workVal = 0, digCount = 0, ovf = 0.
  - Commit with digCount == 0 is legal: outVal = 0, pulse still issued.
- bsp:
  - If digCount > 0: workVal = workVal >> 4 (zero into top nibble); digCount -= 1.
  - If digCount == 0: no change.
  - ovf is not cleared by bsp.
- digit:
  - If digCount < DIGITS: workVal = {workVal[4*DIGITS-5:0], digVal}; digCount += 1.
  - If full: workVal and digCount are unchanged; ovf = 1.
- Derived outputs and pulses:
  - full is combinational from digCount.
  - outValid is 0 on every cycle without a commit event.
- State view, derived from digCount:
  - EMPTY (0): digit → PARTIAL (→ FULL directly when DIGITS == 1).
  - PARTIAL (1..DIGITS-1): digit → PARTIAL or FULL; bsp → PARTIAL or EMPTY.
  - FULL (DIGITS): bsp → PARTIAL; digit stays FULL and sets ovf.
  - Any state: clr or commit → EMPTY.
- Reset mid-entry: all state is lost immediately and asynchronously; there is no partial commit.
- Leading zeros are significant only for digCount, not for value: entering 0,0,5 gives workVal = 0x00000005, digCount = 3.

Test Plan:
- Reset, then enter digits 1,2,3,4 (one rising edge each) → workVal = 0x00001234, digCount = 4, full = 0, outValid never high.
- Enter 8 digits 1..8, then digit 9 → workVal = 0x12345678, full = 1, ovf = 1; then bsp → workVal = 0x01234567, digCount = 7, full = 0, ovf still 1.
- Enter A,B,C, commit → outVal = 0x00000ABC, outValid high exactly one cycle, workVal = 0, digCount = 0, ovf = 0; hold commitEn high 5 cycles → only one pulse.
- Enter 5, then raise clrEn and commitEn on the same edge → clr wins: workVal = 0, outVal keeps its prior value, no outValid pulse.
- bsp with digCount = 0 → no change. Digit held high 10 cycles → exactly one digit entered.
- Enter F,E, assert reset asynchronously mid-cycle → all outputs 0 before the next clock edge. Release reset with digEn held high → one digit entered on the first clock.

Source files
------------

// File: rtl/hex_digit_packer.sv
// -----------------------------------------------------------------------------
// hex_digit_packer
//
// Builds a 4*DIGITS-bit hex word one digit at a time from debounced keypad or
// switch requests. This is the inverse of the display nibble selector. The
// working word drives the display path live. A commit copies it into a
// committed word and pulses outValid for one cycle.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   digVal    in   [3:0] hex digit to enter
//   digEn     in   enter-digit request (level, acts on rising edge)
//   bspEn     in   backspace request   (level, acts on rising edge)
//   clrEn     in   clear request       (level, acts on rising edge)
//   commitEn  in   commit request      (level, acts on rising edge)
//   workVal   out  [4*DIGITS-1:0] live working word, newest digit in [3:0]
//   outVal    out  [4*DIGITS-1:0] last committed word
//   digCount  out  [3:0] digits currently entered, 0..DIGITS
//   full      out  digCount == DIGITS
//   ovf       out  sticky: digit entry attempted while full
//   outValid  out  one-cycle pulse on commit
// -----------------------------------------------------------------------------
module hex_digit_packer #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            digVal,
    input  logic                  digEn,
    input  logic                  bspEn,
    input  logic                  clrEn,
    input  logic                  commitEn,
    output logic [4*DIGITS-1:0]   workVal,
    output logic [4*DIGITS-1:0]   outVal,
    output logic [3:0]            digCount,
    output logic                  full,
    output logic                  ovf,
    output logic                  outValid
);

    localparam int         W       = 4 * DIGITS;
    localparam logic [3:0] DIG_MAX = 4'(DIGITS);

    // Edge-detect history. These clear on reset, so a request that is held
    // high through reset release is seen as a fresh edge on the first clock.
    logic dig_hist_q, bsp_hist_q, clr_hist_q, commit_hist_q;

    logic [W-1:0] work_q, work_d;
    logic [W-1:0] out_q,  out_d;
    logic [3:0]   cnt_q,  cnt_d;
    logic         ovf_q,  ovf_d;
    logic         vld_q,  vld_d;

    // Raw rising-edge events.
    logic dig_ev, bsp_ev, clr_ev, commit_ev;

    // Events after priority resolution. Only one of these is ever high.
    logic do_clr, do_commit, do_bsp, do_dig;

    assign dig_ev    = digEn    & ~dig_hist_q;
    assign bsp_ev    = bspEn    & ~bsp_hist_q;
    assign clr_ev    = clrEn    & ~clr_hist_q;
    assign commit_ev = commitEn & ~commit_hist_q;

    // Priority is clr > commit > bsp > digit. Lower-priority events that
    // arrive on the same edge are dropped, not queued. Their history still
    // updates, so they do not fire on a later edge.
    assign do_clr    = clr_ev;
    assign do_commit = commit_ev & ~clr_ev;
    assign do_bsp    = bsp_ev    & ~clr_ev & ~commit_ev;
    assign do_dig    = dig_ev    & ~clr_ev & ~commit_ev & ~bsp_ev;

    assign full = (cnt_q == DIG_MAX);

    always_comb begin
        work_d = work_q;
        out_d  = out_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        vld_d  = 1'b0;

        if (do_clr) begin
            work_d = '0;
            cnt_d  = 4'd0;
            ovf_d  = 1'b0;
        end else if (do_commit) begin
            // A commit with nothing entered is legal. It commits zero and
            // still pulses.
            out_d  = work_q;
            vld_d  = 1'b1;
            work_d = '0;
            cnt_d  = 4'd0;
            ovf_d  = 1'b0;
        end else if (do_bsp) begin
            // Drop the newest digit. Zero shifts into the top nibble.
            // ovf is deliberately left alone.
            if (cnt_q != 4'd0) begin
                work_d = work_q >> 4;
                cnt_d  = cnt_q - 4'd1;
            end
        end else if (do_dig) begin
            if (cnt_q < DIG_MAX) begin
                // Shift-and-insert. This form stays legal when DIGITS == 1,
                // where a part-select of the lower bits would be empty.
                work_d = (work_q << 4) | W'(digVal);
                cnt_d  = cnt_q + 4'd1;
            end else begin
                ovf_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_hist_q    <= 1'b0;
            bsp_hist_q    <= 1'b0;
            clr_hist_q    <= 1'b0;
            commit_hist_q <= 1'b0;
            work_q        <= '0;
            out_q         <= '0;
            cnt_q         <= 4'd0;
            ovf_q         <= 1'b0;
            vld_q         <= 1'b0;
        end else begin
            dig_hist_q    <= digEn;
            bsp_hist_q    <= bspEn;
            clr_hist_q    <= clrEn;
            commit_hist_q <= commitEn;
            work_q        <= work_d;
            out_q         <= out_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            vld_q         <= vld_d;
        end
    end

    assign workVal  = work_q;
    assign outVal   = out_q;
    assign digCount = cnt_q;
    assign ovf      = ovf_q;
    assign outValid = vld_q;

endmodule
